// File: rtl/btn_debounce_pulse.sv
// Pushbutton conditioner: synchronizes a raw asynchronous input, qualifies it
// over STABLE_CYCLES consecutive samples, and emits a clean registered level,
// single-cycle rise/fall pulses and a wrap-around count of accepted presses.
module btn_debounce_pulse #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3,
  parameter int unsigned PRESS_W       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_in,
  output logic               btn_level,
  output logic               btn_rise,
  output logic               btn_fall,
  output logic [PRESS_W-1:0] press_count
);

  localparam logic [1:0] LOW_STABLE  = 2'd0;
  localparam logic [1:0] LOW_QUAL    = 2'd1;
  localparam logic [1:0] HIGH_STABLE = 2'd2;
  localparam logic [1:0] HIGH_QUAL   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // With a single required sample the QUAL states are bypassed entirely.
  localparam bit SINGLE_SAMPLE = (STABLE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_d, rise_d, fall_d;
  logic [PRESS_W-1:0] press_d;

  // Synchronizer chain: the only logic that touches btn_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // Qualification FSM next-state: a sample equal to the current level aborts QUAL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = btn_level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    press_d = press_count;

    case (state_q)
      LOW_STABLE: begin
        cnt_d = '0;
        if (sync_q) begin
          if (SINGLE_SAMPLE) begin
            state_d = HIGH_STABLE;
            level_d = 1'b1;
            rise_d  = 1'b1;
            press_d = press_count + PRESS_W'(1);
          end else begin
            state_d = LOW_QUAL;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      LOW_QUAL: begin
        if (!sync_q) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          press_d = press_count + PRESS_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HIGH_STABLE: begin
        cnt_d = '0;
        if (!sync_q) begin
          if (SINGLE_SAMPLE) begin
            state_d = LOW_STABLE;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = HIGH_QUAL;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      HIGH_QUAL: begin
        if (sync_q) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset wins over any pending acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOW_STABLE;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_rise    <= 1'b0;
      btn_fall    <= 1'b0;
      press_count <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_rise    <= rise_d;
      btn_fall    <= fall_d;
      press_count <= press_d;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: per-cycle scoreboard against a run-length
// reference, plus a segment table and hand sequences for timing corner cases.
module tb_btn_debounce_pulse;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 4;
  localparam int unsigned PW     = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_in = 1'b0;
  logic          btn_level, btn_rise, btn_fall;
  logic [PW-1:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  btn_debounce_pulse #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (3),
    .PRESS_W      (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          level;
    logic          rise;
    logic          fall;
    logic [PW-1:0] count;
  } exp_t;

  exp_t exp_q[$];

  // Reference: delay line of SYNC samples, then a run length of samples that
  // disagree with the current level; STABLE such samples in a row flip it.
  logic [SYNC-1:0] m_pipe;
  logic            m_level, m_rise, m_fall;
  logic [PW-1:0]   m_cnt;
  int              m_run;

  task automatic model_step(input logic r, input logic b);
    logic s;
    if (r) begin
      m_pipe = '0; m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_cnt = '0; m_run = 0;
    end else begin
      s = m_pipe[SYNC-1];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == STABLE) begin
          m_level = s;
          m_run   = 0;
          if (s) begin
            m_rise = 1'b1;
            m_cnt  = m_cnt + 1'b1;
          end else begin
            m_fall = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_pipe = {m_pipe[SYNC-2:0], b};
    end
  endtask

  task automatic check(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  // One clock: drive, push expectation, sample 1 ns after the edge, pop and compare.
  task automatic cycle(input logic r, input logic b, output logic rise, output logic fall);
    exp_t e;
    exp_t got;
    reset  = r;
    btn_in = b;
    model_step(r, b);
    exp_q.push_back('{level: m_level, rise: m_rise, fall: m_fall, count: m_cnt});
    @(posedge clk);
    #1;
    got  = '{level: btn_level, rise: btn_rise, fall: btn_fall, count: press_count};
    rise = btn_rise;
    fall = btn_fall;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("cycle_outputs", int'(got), int'(e));
    end
    check("rise_fall_exclusive", int'(btn_rise & btn_fall), 0);
  endtask

  // Runs a constant-input segment; first_rise is the 1-based cycle of the first rise.
  task automatic run_seg(input logic r, input logic b, input int n,
                         output int rises, output int falls, output int first_rise);
    logic rs, fl;
    rises = 0; falls = 0; first_rise = 0;
    for (int i = 1; i <= n; i++) begin
      cycle(r, b, rs, fl);
      if (rs) begin
        rises++;
        if (first_rise == 0) first_rise = i;
      end
      if (fl) falls++;
    end
  endtask

  typedef struct {
    logic          rst;
    logic          btn;
    int            cycles;
    logic          exp_level;
    int            exp_rises;
    int            exp_falls;
    logic [PW-1:0] exp_count;
  } seg_t;

  seg_t segs[19];

  initial begin
    int   rises, falls, fr, tot_r, tot_f;
    logic b;
    int   len;

    // Reset with btn_in high, clean press/release, then five presses for wrap.
    segs[0] = '{1'b1, 1'b1, 3,  1'b0, 0, 0, 2'd0};
    segs[1] = '{1'b0, 1'b1, 5,  1'b0, 0, 0, 2'd0};
    segs[2] = '{1'b0, 1'b1, 1,  1'b1, 1, 0, 2'd1};
    segs[3] = '{1'b0, 1'b1, 14, 1'b1, 0, 0, 2'd1};
    segs[4] = '{1'b0, 1'b0, 5,  1'b1, 0, 0, 2'd1};
    segs[5] = '{1'b0, 1'b0, 1,  1'b0, 0, 1, 2'd1};
    segs[6] = '{1'b0, 1'b0, 6,  1'b0, 0, 0, 2'd1};
    segs[7] = '{1'b1, 1'b0, 2,  1'b0, 0, 0, 2'd0};
    segs[8] = '{1'b0, 1'b0, 4,  1'b0, 0, 0, 2'd0};
    for (int k = 1; k <= 5; k++) begin
      segs[7 + 2*k]     = '{1'b0, 1'b1, 8, 1'b1, 1, 0, 2'(k % 4)};
      segs[7 + 2*k + 1] = '{1'b0, 1'b0, 8, 1'b0, 0, 1, 2'(k % 4)};
    end

    for (int i = 0; i < 19; i++) begin
      run_seg(segs[i].rst, segs[i].btn, segs[i].cycles, rises, falls, fr);
      check($sformatf("seg%0d_rises", i), rises, segs[i].exp_rises);
      check($sformatf("seg%0d_falls", i), falls, segs[i].exp_falls);
      check($sformatf("seg%0d_level", i), int'(btn_level), int'(segs[i].exp_level));
      check($sformatf("seg%0d_count", i), int'(press_count), int'(segs[i].exp_count));
    end

    // Bounce: 2 high / 1 low for 30 cycles never survives qualification.
    tot_r = 0; tot_f = 0;
    for (int i = 0; i < 10; i++) begin
      run_seg(1'b0, 1'b1, 2, rises, falls, fr); tot_r += rises; tot_f += falls;
      run_seg(1'b0, 1'b0, 1, rises, falls, fr); tot_r += rises; tot_f += falls;
    end
    run_seg(1'b0, 1'b0, 10, rises, falls, fr); tot_r += rises; tot_f += falls;
    check("bounce_rises", tot_r, 0);
    check("bounce_falls", tot_f, 0);
    check("bounce_level", int'(btn_level), 0);
    check("bounce_count", int'(press_count), 1);

    // Bounce then settle: random runs of 1..3 cycles, last one low, then hold high.
    tot_r = 0;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      len = int'($urandom_range(1, 3));
      run_seg(1'b0, b, len, rises, falls, fr);
      tot_r += rises;
      b = ~b;
    end
    check("settle_bounce_rises", tot_r, 0);
    run_seg(1'b0, 1'b1, 12, rises, falls, fr);
    check("settle_rises", rises, 1);
    check("settle_rise_edge", fr, 6);
    check("settle_count", int'(press_count), 2);
    run_seg(1'b0, 1'b0, 10, rises, falls, fr);
    check("settle_release_falls", falls, 1);

    // Reset mid-qualification: the pending rise is discarded and restarts.
    run_seg(1'b0, 1'b1, 4, rises, falls, fr);
    check("midq_pre_rises", rises, 0);
    run_seg(1'b1, 1'b1, 1, rises, falls, fr);
    check("midq_reset_rises", rises, 0);
    check("midq_reset_count", int'(press_count), 0);
    check("midq_reset_level", int'(btn_level), 0);
    run_seg(1'b0, 1'b1, 10, rises, falls, fr);
    check("midq_rises", rises, 1);
    check("midq_rise_edge", fr, 6);
    check("midq_count", int'(press_count), 1);
    check("midq_level", int'(btn_level), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
